// File: rtl/mire_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mire_pkg
// Description : Shared types and constants for the mire_gen pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package mire_pkg;

    typedef enum logic [1:0] {
        MIRE_GRID  = 2'd0,
        MIRE_BARS  = 2'd1,
        MIRE_CHECK = 2'd2,
        MIRE_SOLID = 2'd3
    } mire_mode_e;

    localparam logic [15:0] c_white   = 16'hFFFF;
    localparam logic [15:0] c_yellow  = 16'hFFE0;
    localparam logic [15:0] c_cyan    = 16'h07FF;
    localparam logic [15:0] c_green   = 16'h07E0;
    localparam logic [15:0] c_magenta = 16'hF81F;
    localparam logic [15:0] c_red     = 16'hF800;
    localparam logic [15:0] c_blue    = 16'h001F;
    localparam logic [15:0] c_black   = 16'h0000;

    localparam logic [2:0] c_cti_inc = 3'b010;
    localparam logic [2:0] c_cti_end = 3'b111;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_burst = 2'd1;
    localparam logic [1:0] c_st_gap   = 2'd2;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] col;
        case (idx)
            3'd0:    col = c_white;
            3'd1:    col = c_yellow;
            3'd2:    col = c_cyan;
            3'd3:    col = c_green;
            3'd4:    col = c_magenta;
            3'd5:    col = c_red;
            3'd6:    col = c_blue;
            default: col = c_black;
        endcase
        return col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mire_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : wshb_if
// Description : Write-only Wishbone B4 bus between the pattern generator and
//               the SDRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface wshb_if;
    logic [31:0] adr;
    logic [15:0] dat_ms;
    logic [1:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (output adr, dat_ms, sel, we, cyc, stb, cti, bte, input ack);
    modport slave  (input adr, dat_ms, sel, we, cyc, stb, cti, bte, output ack);
endinterface
`default_nettype wire

// File: rtl/mire_pattern.sv
`default_nettype none
// ============================================================================
// Module      : mire_pattern
// Description : Combinational RGB565 pixel generator for a given (x, y, mode).
// Revision    : 1.0 - initial release
// ============================================================================
module mire_pattern
    import mire_pkg::*;
#(
    parameter int HDISP = 640,
    parameter int GRID  = 16,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  wire logic [XW-1:0] i_x,
    input  wire logic [YW-1:0] i_y,
    input  wire mire_mode_e    i_mode,
    input  wire logic [15:0]   i_solid_color,
    output logic [15:0]        o_pixel
);

    localparam int c_bar_w = HDISP / 8;

    logic       w_on_grid;
    logic       w_checker;
    logic [2:0] w_bar_idx;

    assign w_on_grid = ((32'(i_x) % GRID) == 0) || ((32'(i_y) % GRID) == 0);
    assign w_checker = 1'((32'(i_x) / GRID) ^ (32'(i_y) / GRID));
    assign w_bar_idx = 3'(32'(i_x) / c_bar_w);

    always_comb begin
        o_pixel = c_black;
        case (i_mode)
            MIRE_GRID:  o_pixel = w_on_grid ? c_white : c_black;
            MIRE_BARS:  o_pixel = bar_color(w_bar_idx);
            MIRE_CHECK: o_pixel = w_checker ? c_white : c_black;
            MIRE_SOLID: o_pixel = i_solid_color;
            default:    o_pixel = c_black;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mire_gen.sv
`default_nettype none
// ============================================================================
// Module      : mire_gen
// Description : Wishbone burst master writing one RGB565 test-pattern frame
//               at a time into the frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module mire_gen
    import mire_pkg::*;
#(
    parameter int          HDISP     = 640,
    parameter int          VDISP     = 480,
    parameter int unsigned BASE_ADR  = 0,
    parameter int          GRID      = 16,
    parameter int          BURST_LEN = 8,
    parameter int          GAP       = 64
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        enable,
    input  wire logic [1:0]  mode,
    input  wire logic [15:0] solid_color,
    output logic             frame_done,
    wshb_if.master           wshb_if_mire
);

    localparam int c_xw    = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int c_yw    = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int c_bw    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int c_gw    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int c_ratio = GRID / BURST_LEN;

    if (HDISP % BURST_LEN != 0) begin : g_chk_burst_div
        $error("mire_gen: HDISP must be a multiple of BURST_LEN");
    end
    if (c_ratio == 0 || (c_ratio & (c_ratio - 1)) != 0) begin : g_chk_grid_ratio
        $error("mire_gen: GRID/BURST_LEN must be a power of 2");
    end

    logic [1:0]      r_state;
    logic [c_xw-1:0] r_x;
    logic [c_yw-1:0] r_y;
    logic [c_bw-1:0] r_beat;
    logic [c_gw-1:0] r_gap;
    mire_mode_e      r_mode;
    logic [15:0]     r_solid;
    logic            r_frame_done;

    logic            w_x_end;
    logic            w_y_end;
    logic            w_last_beat;
    logic            w_origin;
    logic            w_origin_nxt;
    logic [c_xw-1:0] w_x_nxt;
    logic [c_yw-1:0] w_y_nxt;
    logic [31:0]     w_pix_idx;
    logic [15:0]     w_pixel;

    assign w_x_end      = (r_x == c_xw'(HDISP - 1));
    assign w_y_end      = (r_y == c_yw'(VDISP - 1));
    assign w_last_beat  = (r_beat == c_bw'(BURST_LEN - 1));
    assign w_x_nxt      = w_x_end ? '0 : r_x + 1'b1;
    assign w_y_nxt      = !w_x_end ? r_y : (w_y_end ? '0 : r_y + 1'b1);
    assign w_origin     = (r_x == '0) && (r_y == '0);
    assign w_origin_nxt = (w_x_nxt == '0) && (w_y_nxt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_x          <= '0;
            r_y          <= '0;
            r_beat       <= '0;
            r_gap        <= '0;
            r_mode       <= MIRE_GRID;
            r_solid      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (enable) begin
                        r_state <= c_st_burst;
                        r_beat  <= '0;
                        if (w_origin) begin
                            r_mode  <= mire_mode_e'(mode);
                            r_solid <= solid_color;
                        end
                    end
                end
                c_st_burst: begin
                    if (wshb_if_mire.ack) begin
                        r_x    <= w_x_nxt;
                        r_y    <= w_y_nxt;
                        r_beat <= r_beat + 1'b1;
                        if (w_x_end && w_y_end) begin
                            r_frame_done <= 1'b1;
                        end
                        if (w_last_beat) begin
                            r_beat <= '0;
                            if (GAP > 0) begin
                                r_state <= c_st_gap;
                                r_gap   <= '0;
                            end else if (enable) begin
                                // back-to-back bursts: a new frame may start here
                                if (w_origin_nxt) begin
                                    r_mode  <= mire_mode_e'(mode);
                                    r_solid <= solid_color;
                                end
                            end else begin
                                r_state <= c_st_idle;
                            end
                        end
                    end
                end
                c_st_gap: begin
                    if (r_gap == c_gw'(GAP - 1)) begin
                        if (enable) begin
                            r_state <= c_st_burst;
                            if (w_origin) begin
                                r_mode  <= mire_mode_e'(mode);
                                r_solid <= solid_color;
                            end
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    mire_pattern #(
        .HDISP (HDISP),
        .GRID  (GRID),
        .XW    (c_xw),
        .YW    (c_yw)
    ) u_pattern (
        .i_x           (r_x),
        .i_y           (r_y),
        .i_mode        (r_mode),
        .i_solid_color (r_solid),
        .o_pixel       (w_pixel)
    );

    assign w_pix_idx = 32'(HDISP) * 32'(r_y) + 32'(r_x);

    assign wshb_if_mire.adr    = 32'(BASE_ADR) + (w_pix_idx << 1);
    assign wshb_if_mire.dat_ms = w_pixel;
    assign wshb_if_mire.sel    = 2'b11;
    assign wshb_if_mire.we     = 1'b1;
    assign wshb_if_mire.bte    = 2'b00;
    assign wshb_if_mire.cyc    = (r_state == c_st_burst);
    assign wshb_if_mire.stb    = (r_state == c_st_burst);
    assign wshb_if_mire.cti    = w_last_beat ? c_cti_end : c_cti_inc;
    assign frame_done          = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_mire_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_mire_gen
// Description : Scoreboard bench for mire_gen on a small 64x4 frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mire_gen;
    import mire_pkg::*;

    localparam int          HD   = 64;
    localparam int          VD   = 4;
    localparam int          BL   = 8;
    localparam int          GP   = 3;
    localparam int          GR   = 16;
    localparam int unsigned BASE = 32'h0000_1000;

    typedef struct {
        logic [31:0] adr;
        logic [15:0] dat;
        logic [2:0]  cti;
        bit          last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] solid_color;
    logic        frame_done;

    wshb_if bus ();

    mire_gen #(
        .HDISP     (HD),
        .VDISP     (VD),
        .BASE_ADR  (BASE),
        .GRID      (GR),
        .BURST_LEN (BL),
        .GAP       (GP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .solid_color  (solid_color),
        .frame_done   (frame_done),
        .wshb_if_mire (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // slave: acks after wait_states stalled cycles
    int wait_states = 0;
    int wcnt = 0;
    assign bus.ack = bus.cyc && bus.stb && (wcnt >= wait_states);
    always @(posedge clk) begin
        if (bus.cyc && bus.stb && !bus.ack) wcnt <= wcnt + 1;
        else                                wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_pix(input int x, input int y,
                                              input logic [1:0] m, input logic [15:0] s);
        logic [15:0] p;
        case (m)
            2'd0: p = ((x % GR == 0) || (y % GR == 0)) ? 16'hFFFF : 16'h0000;
            2'd1: begin
                case (x / (HD / 8))
                    0: p = 16'hFFFF;  1: p = 16'hFFE0;  2: p = 16'h07FF;  3: p = 16'h07E0;
                    4: p = 16'hF81F;  5: p = 16'hF800;  6: p = 16'h001F;  default: p = 16'h0000;
                endcase
            end
            2'd2: p = (((x / GR) ^ (y / GR)) % 2 == 1) ? 16'hFFFF : 16'h0000;
            default: p = s;
        endcase
        return p;
    endfunction

    task automatic push_frame(input logic [1:0] m, input logic [15:0] s);
        exp_t e;
        for (int y = 0; y < VD; y++) begin
            for (int x = 0; x < HD; x++) begin
                e.adr  = 32'(BASE + 2 * (HD * y + x));
                e.dat  = model_pix(x, y, m, s);
                e.cti  = (x % BL == BL - 1) ? 3'b111 : 3'b010;
                e.last = (x == HD - 1) && (y == VD - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // monitor: scoreboard, stall stability, burst/gap lengths, frame_done timing
    bit          mon_on = 0;
    bit          timing_on = 0;
    bit          exp_done = 0;
    bit          stalled = 0;
    bit          prev_cyc = 0;
    bit          had_burst = 0;
    int          ack_cnt = 0;
    int          done_cnt = 0;
    int          burst_beat = 0;
    int          last_burst_len = 0;
    int          hi_run = 0;
    int          lo_run = 0;
    logic [31:0] held_adr;
    logic [15:0] held_dat;
    logic [2:0]  held_cti;

    always @(negedge clk) begin
        if (mon_on) begin
            exp_t e;
            chk("frame_done", 32'(frame_done), 32'(exp_done));
            if (frame_done) done_cnt++;
            exp_done = 0;
            if (bus.cyc && bus.stb) begin
                if (stalled) begin
                    chk("stall_adr", bus.adr, held_adr);
                    chk("stall_dat", 32'(bus.dat_ms), 32'(held_dat));
                    chk("stall_cti", 32'(bus.cti), 32'(held_cti));
                end
                held_adr = bus.adr;
                held_dat = bus.dat_ms;
                held_cti = bus.cti;
                stalled  = !bus.ack;
            end else begin
                stalled = 0;
            end
            if (bus.ack) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_ack observed adr=%h expected no write", bus.adr);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("adr", bus.adr, e.adr);
                    chk("dat", 32'(bus.dat_ms), 32'(e.dat));
                    chk("cti", 32'(bus.cti), 32'(e.cti));
                    exp_done = e.last;
                end
                ack_cnt++;
                burst_beat++;
            end
            if (bus.cyc) begin
                if (!prev_cyc) begin
                    if (timing_on && had_burst) chk("gap_len", 32'(lo_run), 32'(GP));
                    hi_run = 0;
                end
                hi_run++;
            end else begin
                if (prev_cyc) begin
                    last_burst_len = burst_beat;
                    if (timing_on) chk("burst_len", 32'(hi_run), 32'(BL));
                    had_burst  = 1;
                    lo_run     = 0;
                    burst_beat = 0;
                end
                lo_run++;
            end
            prev_cyc = bus.cyc;
        end
    end

    task automatic wait_done(input int n);
        int t = 0;
        while (done_cnt < n && t < 4000) begin @(posedge clk); #1; t++; end
        chk("done_count", 32'(done_cnt), 32'(n));
    endtask

    task automatic wait_acks(input int n);
        int t = 0;
        while (ack_cnt < n && t < 4000) begin @(posedge clk); #1; t++; end
        chk("ack_reach", 32'(ack_cnt >= n), 32'd1);
    endtask

    task automatic wait_beat(input int b);
        int t = 0;
        while (!(bus.cyc && burst_beat == b) && t < 200) begin @(posedge clk); #1; t++; end
        chk("beat_reach", 32'(burst_beat), 32'(b));
    endtask

    initial begin
        int drop_acks;
        int hi_seen;
        int saved_done;
        int t;

        rst_n = 1'b0; enable = 1'b0; mode = 2'd0; solid_color = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        mon_on = 1;
        chk("rst_cyc", 32'(bus.cyc), 32'd0);
        chk("rst_stb", 32'(bus.stb), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("const_we", 32'(bus.we), 32'd1);
        chk("const_sel", 32'(bus.sel), 32'd3);
        chk("const_bte", 32'(bus.bte), 32'd0);

        push_frame(MIRE_GRID, 16'h0);
        push_frame(MIRE_BARS, 16'h0);
        push_frame(MIRE_SOLID, 16'h1234);
        push_frame(MIRE_SOLID, 16'h1234);

        // frame 1: grid, zero-wait slave, burst/gap timing checked
        timing_on = 1;
        rst_n = 1'b1; enable = 1'b1;
        wait_acks(20);
        mode = MIRE_BARS;
        wait_done(1);
        timing_on = 0;

        // frame 2: bars with 2 wait states; request solid mid-frame
        wait_states = 2;
        wait_acks(HD * VD + 40);
        mode = MIRE_SOLID; solid_color = 16'h1234;
        wait_done(2);
        wait_states = 0;

        // frame 3: drop enable on beat 3 of a burst
        wait_acks(2 * HD * VD + 50);
        wait_beat(2);
        drop_acks = ack_cnt;
        enable = 1'b0;
        t = 0;
        while (bus.cyc && t < 50) begin @(posedge clk); #1; t++; end
        @(negedge clk); #1;
        chk("drop_burst_len", 32'(last_burst_len), 32'(BL));
        chk("drop_beats", 32'(ack_cnt - drop_acks), 32'(BL - 2));
        hi_seen = 0;
        repeat (30) begin @(posedge clk); #1; if (bus.cyc) hi_seen++; end
        chk("idle_cyc", 32'(hi_seen), 32'd0);
        enable = 1'b1;
        wait_done(3);

        // frame 4: reset during beat 5
        wait_beat(4);
        saved_done = done_cnt;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_cyc", 32'(bus.cyc), 32'd0);
        chk("rst_mid_stb", 32'(bus.stb), 32'd0);
        exp_q.delete();
        mode = MIRE_CHECK;
        push_frame(MIRE_CHECK, 16'h0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_done_after_rst", 32'(done_cnt), 32'(saved_done));
        wait_done(saved_done + 1);
        enable = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_idle", 32'(bus.cyc), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
